pulse_window_counter: RTL
=========================

PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

Interface
REQ-001 Parameter WINDOW, default 16: window length in clk cycles (>=2).
REQ-002 Parameter CNT_W, default 8: width of the count result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 pulse_in  input  1  asynchronous level from upstream pulse detector output.
REQ-006 cnt_out  output  CNT_W  rising-edge count of the last closed window.
REQ-007 sat  output  1  cnt_out saturated during its window.
REQ-008 overrun  output  1  at least one earlier unconsumed result was overwritten.
REQ-009 cnt_valid  output  1  cnt_out/sat/overrun hold a result.
REQ-010 cnt_ready  input  1  consumer accepts the result when high with cnt_valid.

Function
REQ-011 pulse_in SHALL pass a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-012 A 0->1 on pulse_in set up before edge k SHALL increment the accumulator acc at edge k+2; each rising transition counts once regardless of high duration.
REQ-013 Window timer tmr SHALL count 0..WINDOW-1 and wrap to 0; a window closes at the edge where tmr==WINDOW-1.
REQ-014 A rise present on the closing cycle SHALL be counted in the closing window.
REQ-015 At window close: captured value = acc (+1 if rise), saturating; acc cleared to 0 and its saturation flag cleared.
REQ-016 acc SHALL saturate at 2^CNT_W-1; further rises set the window's saturation flag, no wrap-around.
REQ-017 Output FSM has two states, EMPTY (cnt_valid=0) and FULL (cnt_valid=1).
REQ-018 EMPTY + close -> FULL; cnt_out/sat loaded, overrun=0.
REQ-019 FULL + cnt_ready=1, no close -> EMPTY at that edge; cnt_out holds last value.
REQ-020 FULL + close + cnt_ready=1 at same edge -> stay FULL, new result loaded, overrun=0.
REQ-021 FULL + close + cnt_ready=0 -> stay FULL, new result overwrites, overrun=1.
REQ-022 While FULL with no close, cnt_out, sat, overrun SHALL remain stable.
REQ-023 cnt_valid is registered; it rises the cycle after the capture edge (one-cycle capture latency).
REQ-024 cnt_ready while EMPTY SHALL be ignored.

Reset
REQ-025 rst=0 SHALL immediately force s1, s2, s3, acc, tmr, cnt_out, sat, overrun, cnt_valid to 0 and FSM to EMPTY, independent of clk.
REQ-026 After rst rises, the first clk edge SHALL start a new window with tmr=0; a pulse_in held high through reset release counts as one rise.
REQ-027 Reset asserted mid-window or with a pending result SHALL discard both; no result emitted for the aborted window.

Verification
REQ-028 Reset, cnt_ready=1, 3 pulses (2 high/2 low) in first window -> cnt_valid=1 after 16th edge, cnt_out=3, sat=0, overrun=0; cleared next edge.
REQ-029 pulse_in held high across an entire window (rising once inside it) -> cnt_out=1; next window with no new edge -> cnt_out=0.
REQ-030 cnt_ready=0, 2 pulses in window 1, 5 in window 2 -> after window 2 cnt_out=5, overrun=1; then cnt_ready=1 -> cnt_valid=0 next edge.
REQ-031 CNT_W=2, 6 pulses in one window -> cnt_out=3, sat=1; next window of 1 pulse -> cnt_out=1, sat=0.
REQ-032 acc=4 and cnt_valid=1, rst pulsed low mid-cycle -> all outputs 0 without clk edge; after release, first result arrives 16 edges later.
REQ-033 cnt_ready=1 exactly on a close edge while FULL -> cnt_valid stays 1, cnt_out = new count, overrun=0.

Source files
------------

// File: rtl/pulse_window_counter.sv
// Counts synchronized rising edges of pulse_in over fixed WINDOW-cycle windows; result registered 1 cycle after close.
// One-entry result holder: an unconsumed result is overwritten by the next close and flagged with overrun.
module pulse_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             sat,
    output logic             overrun,
    output logic             cnt_valid,
    input  logic             cnt_ready
);
    localparam int               TMR_W    = $clog2(WINDOW);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic             close;
    logic             acc_full;
    logic [CNT_W-1:0] cap_cnt;
    logic             cap_sat;
    state_t           state_q;

    assign rise     = s2_q & ~s3_q;
    assign close    = (tmr_q == TMR_LAST);
    assign acc_full = (acc_q == CNT_MAX);

    // A rise on the closing cycle belongs to the closing window.
    assign cap_cnt = (rise && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
    assign cap_sat = acc_sat_q | (rise & acc_full);

    always_comb begin
        tmr_d     = close ? '0 : tmr_q + TMR_W'(1);
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        if (close) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end else if (rise) begin
            if (acc_full) begin
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            tmr_q     <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            s1_q      <= pulse_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            tmr_q     <= tmr_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            cnt_out   <= '0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
            cnt_valid <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (close) begin
                        state_q   <= FULL;
                        cnt_valid <= 1'b1;
                        cnt_out   <= cap_cnt;
                        sat       <= cap_sat;
                        overrun   <= 1'b0;
                    end
                end
                FULL: begin
                    if (close) begin
                        cnt_out <= cap_cnt;
                        sat     <= cap_sat;
                        overrun <= ~cnt_ready;
                    end else if (cnt_ready) begin
                        state_q   <= EMPTY;
                        cnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    cnt_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
